// File: rtl/velocity_cell_writer.sv
// Write-side controller for one cell's velocity RAM: streams particles to
// addresses 1..N in arrival order, then writes the count N to address 0.
module velocity_cell_writer #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_end,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] particle_count
);

  typedef enum logic [1:0] {IDLE, STREAM, WR_CNT, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state_q, state_d;
  logic                  cnt_written_q, cnt_written_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;

  logic beat, end_acc, room, write_beat;

  assign beat       = (state_q == STREAM) && in_valid;
  assign end_acc    = (state_q == STREAM) && in_end;
  assign room       = count_q < MAX_CNT;
  assign write_beat = beat && room;

  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, so the ordering of statements here cannot matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_written_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_written_q <= cnt_written_d;
    end
  end

  // A count word written in the same edge as in_end skips the WR_CNT write.
  always_comb begin
    state_d       = state_q;
    cnt_written_d = cnt_written_q;
    unique case (state_q)
      IDLE:   if (start) begin
                state_d       = STREAM;
                cnt_written_d = 1'b0;
              end
      STREAM: if (in_end) begin
                state_d       = WR_CNT;
                cnt_written_d = !write_beat;
              end
      WR_CNT: if (cnt_written_q) state_d = DONE;
              else               cnt_written_d = 1'b1;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every _d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: if (start) begin
        count_d = '0;
        ovf_d   = 1'b0;
        busy_d  = 1'b1;
        ready_d = 1'b1;
      end
      STREAM: begin
        if (write_beat) begin
          wren_d  = 1'b1;
          addr_d  = count_q + ADDR_WIDTH'(1);
          data_d  = in_data;
          count_d = count_q + ADDR_WIDTH'(1);
        end else if (beat) begin
          ovf_d = 1'b1;
        end
        if (end_acc) begin
          ready_d = 1'b0;
          if (!write_beat) begin
            wren_d = 1'b1;
            addr_d = '0;
            data_d = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, count_q};
          end
        end
      end
      WR_CNT: begin
        if (!cnt_written_q) begin
          wren_d = 1'b1;
          addr_d = '0;
          data_d = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, count_q};
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_data       = data_q;
  assign mem_wren       = wren_q;
  assign mem_rden       = 1'b0;
  assign in_ready       = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign particle_count = count_q;

endmodule
